// File: rtl/output_signature_compactor.sv
// Folds wide DUT output words into a MISR and exposes the signature on a few pins:
// a serial MSB-first unload port and a registered parity bit.
module output_signature_compactor #(
  parameter int               WIDTH     = 32,
  parameter int               NUM_WORDS = 4,
  parameter logic [WIDTH-1:0] POLY      = 32'h04C11DB7,
  parameter logic [WIDTH-1:0] SEED      = 32'h00000001
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_WORDS*WIDTH-1:0] data_i,
  input  logic                       sample_en,
  input  logic                       sig_clear,
  input  logic                       unload_req,
  output logic                       sig_out,
  output logic                       sig_valid,
  output logic                       unload_done,
  output logic                       busy,
  output logic                       sig_parity
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {ACCUM, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sig;
  logic [WIDTH-1:0] shift;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] fold;
  logic [WIDTH-1:0] misr_next;

  always_comb begin
    fold = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      fold = fold ^ data_i[k*WIDTH +: WIDTH];
    end
  end

  assign misr_next = {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ fold;

  // The signature keeps accumulating regardless of unload activity.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sig        <= SEED;
      sig_parity <= 1'b0;
    end else begin
      if (sig_clear) begin
        sig <= SEED;
      end else if (sample_en) begin
        sig <= misr_next;
      end
      sig_parity <= ^sig;
    end
  end

  // The MSB goes straight to sig_out on the load edge, so the shift register
  // holds the remaining bits already moved up by one position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ACCUM;
      shift       <= '0;
      count       <= '0;
      sig_out     <= 1'b0;
      sig_valid   <= 1'b0;
      unload_done <= 1'b0;
      busy        <= 1'b0;
    end else begin
      unload_done <= 1'b0;
      case (state)
        ACCUM: begin
          if (unload_req) begin
            state     <= SHIFT;
            shift     <= {sig[WIDTH-2:0], 1'b0};
            count     <= CW'(WIDTH - 1);
            sig_out   <= sig[WIDTH-1];
            sig_valid <= 1'b1;
            busy      <= 1'b1;
          end else begin
            sig_out   <= 1'b0;
            sig_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        SHIFT: begin
          if (count == '0) begin
            state       <= ACCUM;
            sig_out     <= 1'b0;
            sig_valid   <= 1'b0;
            busy        <= 1'b0;
            unload_done <= 1'b1;
          end else begin
            sig_out   <= shift[WIDTH-1];
            shift     <= {shift[WIDTH-2:0], 1'b0};
            count     <= count - 1'b1;
            sig_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        default: begin
          state     <= ACCUM;
          sig_out   <= 1'b0;
          sig_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_signature_compactor.sv
// Directed bench for output_signature_compactor (WIDTH=8, NUM_WORDS=2, POLY=1D, SEED=01).
// Signatures are observed only through the serial unload port and sig_parity.
module tb_output_signature_compactor;

  logic        clk;
  logic        reset;
  logic [15:0] data_i;
  logic        sample_en;
  logic        sig_clear;
  logic        unload_req;
  logic        sig_out;
  logic        sig_valid;
  logic        unload_done;
  logic        busy;
  logic        sig_parity;

  int num_checks;
  int num_fail;

  typedef struct {
    logic        clear;
    logic        sample;
    logic [15:0] data;
    logic [7:0]  exp_sig;
  } vec_t;

  vec_t vecs [10];

  output_signature_compactor #(
    .WIDTH     (8),
    .NUM_WORDS (2),
    .POLY      (8'h1D),
    .SEED      (8'h01)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data_i      (data_i),
    .sample_en   (sample_en),
    .sig_clear   (sig_clear),
    .unload_req  (unload_req),
    .sig_out     (sig_out),
    .sig_valid   (sig_valid),
    .unload_done (unload_done),
    .busy        (busy),
    .sig_parity  (sig_parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of clear/sample, returns at the negedge after the update edge.
  task automatic applyStimulus(input logic clr, input logic smp, input logic [15:0] d);
    @(negedge clk);
    sig_clear = clr;
    sample_en = smp;
    data_i    = d;
    @(negedge clk);
    sig_clear = 1'b0;
    sample_en = 1'b0;
    data_i    = '0;
  endtask

  task automatic readFrame(input logic [7:0] expected, input string tag);
    logic [7:0] got;
    logic       flags_ok;
    got        = '0;
    flags_ok   = 1'b1;
    unload_req = 1'b1;
    @(negedge clk);
    unload_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = {got[6:0], sig_out};
      if (sig_valid !== 1'b1 || busy !== 1'b1) flags_ok = 1'b0;
      @(negedge clk);
    end
    checkOutput({tag, " frame"}, got, expected);
    checkOutput({tag, " valid/busy"}, flags_ok, 1);
    checkOutput({tag, " done"}, unload_done, 1);
    checkOutput({tag, " idle valid"}, sig_valid, 0);
    @(negedge clk);
    checkOutput({tag, " done pulse"}, unload_done, 0);
  endtask

  initial begin
    logic [7:0] prev_sig;
    logic [7:0] got;
    logic       flags_ok;
    logic       stray;

    num_checks = 0;
    num_fail   = 0;
    reset      = 1'b0;
    data_i     = '0;
    sample_en  = 1'b0;
    sig_clear  = 1'b0;
    unload_req = 1'b0;

    vecs[0] = '{1'b0, 1'b1, 16'hF00F, 8'hFD};
    vecs[1] = '{1'b1, 1'b0, 16'h0000, 8'h01};
    vecs[2] = '{1'b0, 1'b1, 16'h8200, 8'h80};
    vecs[3] = '{1'b0, 1'b1, 16'h0000, 8'h1D};
    vecs[4] = '{1'b0, 1'b1, 16'h0000, 8'h3A};
    vecs[5] = '{1'b0, 1'b0, 16'hFFFF, 8'h3A};
    vecs[6] = '{1'b1, 1'b1, 16'h1234, 8'h01};
    vecs[7] = '{1'b0, 1'b1, 16'h5500, 8'h57};
    vecs[8] = '{1'b0, 1'b1, 16'h0000, 8'hAE};
    vecs[9] = '{1'b0, 1'b1, 16'h0000, 8'h41};

    repeat (3) @(negedge clk);
    checkOutput("reset sig_out", sig_out, 0);
    checkOutput("reset sig_valid", sig_valid, 0);
    checkOutput("reset unload_done", unload_done, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset sig_parity", sig_parity, 0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] table vectors");
    prev_sig = 8'h01;
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].clear, vecs[v].sample, vecs[v].data);
      checkOutput($sformatf("vec%0d parity lag", v), sig_parity, ^prev_sig);
      @(negedge clk);
      checkOutput($sformatf("vec%0d parity", v), sig_parity, ^vecs[v].exp_sig);
      readFrame(vecs[v].exp_sig, $sformatf("vec%0d", v));
      prev_sig = vecs[v].exp_sig;
    end

    $display("[TB] accumulate and clear during unload");
    applyStimulus(1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'hA700);
    unload_req = 1'b1;
    @(negedge clk);
    unload_req = 1'b0;
    got      = '0;
    flags_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      got = {got[6:0], sig_out};
      if (sig_valid !== 1'b1 || busy !== 1'b1) flags_ok = 1'b0;
      case (i)
        1: begin sample_en = 1'b1; data_i = 16'h00FF; end
        2: begin sample_en = 1'b0; data_i = '0; end
        3: begin sig_clear = 1'b1; sample_en = 1'b1; data_i = 16'h1234; end
        4: begin sig_clear = 1'b0; sample_en = 1'b0; data_i = '0; end
        5: unload_req = 1'b1;
        6: unload_req = 1'b0;
        default: ;
      endcase
      @(negedge clk);
    end
    checkOutput("busy-unload frame", got, 8'hA5);
    checkOutput("busy-unload valid/busy", flags_ok, 1);
    checkOutput("busy-unload done", unload_done, 1);
    @(negedge clk);
    checkOutput("ignored req valid", sig_valid, 0);
    checkOutput("ignored req busy", busy, 0);
    readFrame(8'h01, "after clear");
    applyStimulus(1'b0, 1'b1, 16'h0010);
    readFrame(8'h12, "resume");

    $display("[TB] back-to-back unload");
    applyStimulus(1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'h3C00);
    @(negedge clk);
    unload_req = 1'b1;
    sample_en  = 1'b1;
    data_i     = '0;
    @(negedge clk);
    sample_en = 1'b0;
    got       = '0;
    flags_ok  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      got = {got[6:0], sig_out};
      if (sig_valid !== 1'b1) flags_ok = 1'b0;
      @(negedge clk);
    end
    checkOutput("b2b frame1", got, 8'h3E);
    checkOutput("b2b frame1 valid", flags_ok, 1);
    checkOutput("b2b gap valid", sig_valid, 0);
    checkOutput("b2b gap done", unload_done, 1);
    @(negedge clk);
    got      = '0;
    flags_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      got = {got[6:0], sig_out};
      if (sig_valid !== 1'b1) flags_ok = 1'b0;
      if (i == 7) unload_req = 1'b0;
      @(negedge clk);
    end
    checkOutput("b2b frame2", got, 8'h7C);
    checkOutput("b2b frame2 valid", flags_ok, 1);
    checkOutput("b2b end done", unload_done, 1);
    @(negedge clk);
    checkOutput("b2b end valid", sig_valid, 0);
    checkOutput("b2b end busy", busy, 0);

    $display("[TB] reset during unload");
    applyStimulus(1'b1, 1'b0, 16'h0000);
    applyStimulus(1'b0, 1'b1, 16'hA700);
    unload_req = 1'b1;
    @(negedge clk);
    unload_req = 1'b0;
    got = '0;
    for (int i = 0; i < 4; i++) begin
      got = {got[6:0], sig_out};
      @(negedge clk);
    end
    checkOutput("abort first nibble", got, 8'h0A);
    reset = 1'b0;
    #1;
    checkOutput("abort sig_out", sig_out, 0);
    checkOutput("abort sig_valid", sig_valid, 0);
    checkOutput("abort busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (unload_done !== 1'b0 || sig_valid !== 1'b0 || busy !== 1'b0) stray = 1'b1;
      @(negedge clk);
    end
    checkOutput("abort no done", stray, 0);
    readFrame(8'h01, "post-abort");

    $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fail);
    $finish;
  end

endmodule
